vga_sync_monitor: RTL and testbench
===================================

# vga_sync_monitor

Receive-side VGA timing monitor: the other end of the VGA sync generator. It samples incoming `h_sync`/`v_sync`, checks line and frame timing against the 640x480 raster the generator produces, and declares lock. Once locked, it regenerates pixel coordinates and data-enable for downstream capture and checking logic. It sits at the input of a capture path, or in a loopback test harness fed by the sync generator.

## Interface

Parameters:
- `CLK_PER_LINE`, 1600: clocks per line (800 pixels x 2).
- `HS_LEN`, 192: clocks `h_sync` is low per line.
- `H_ACT_START`, 288: clocks from `h_sync` fall to the first active pixel.
- `H_ACT_LEN`, 1280: active clocks per line.
- `LINES_PER_FRAME`, 521: lines per frame.
- `V_ACT_START`, 31: index of the first active line.
- `V_ACT_LINES`, 480: active lines per frame.
- `LOCK_FRAMES`, 2: consecutive good frames required to lock.

Ports:
- `clk` in 1: system clock (2 clocks per pixel).
- `reset` in 1: asynchronous, active-high.
- `h_sync` in 1: horizontal sync, active-low, asynchronous to `clk`.
- `v_sync` in 1: vertical sync, active-low, asynchronous to `clk`.
- `locked` out 1: timing verified; reset 0.
- `de` out 1: active-video enable; reset 0.
- `pix_x` out 10: pixel column 0..639 while `de`, else 0; reset 0.
- `line_y` out 9: line 0..479 while `de`, else 0; reset 0.
- `frame_start` out 1: one-clock pulse at each frame boundary; reset 0.
- `sync_err` out 1: one-clock pulse on any timing violation; reset 0.

## Operation

Input capture:
- Each sync passes through a 2-flop synchronizer; the flops reset to 1 (idle).
- A falling or rising edge is detected on the synchronized value.

Horizontal counting:
- `h_cnt` is 11 bits and increments every clock.
- It saturates at 2047.
- On `h_sync` fall, `h_cnt` loads 0.

Line checks:
- On `h_sync` rise, the low width `h_cnt+1` must equal `HS_LEN`.
- On `h_sync` fall, the line period `h_cnt+1` must equal `CLK_PER_LINE`.
- The period check is skipped on the first fall after reset or after a timeout.

Vertical counting:
- `v_cnt` is 10 bits.
- A `v_sync` fall sets `vs_pend`.
- On the next `h_sync` fall (the same cycle counts), `v_cnt` loads 0, `vs_pend` clears, and `frame_start` pulses.
- Otherwise, each `h_sync` fall increments `v_cnt`; it saturates at 1023.

Frame check:
- At a frame boundary, the completed frame is good when `v_cnt+1 == LINES_PER_FRAME` and no line violation occurred during it.
- The first partial frame after reset or a loss of lock is not judged.

Lock state machine:
- States:
  - ACQUIRE: `good_cnt` counts good frames.
  - LOCKED.
- ACQUIRE -> LOCKED when `good_cnt` reaches `LOCK_FRAMES`.
- Any violation in either state:
  - pulses `sync_err`;
  - clears `good_cnt`;
  - forces ACQUIRE;
  - marks the current frame unjudged.
- Violations are: a width mismatch, a period mismatch, a frame-length mismatch, or `h_cnt` saturating (timeout).

Output generation:
- `de` = LOCKED && `H_ACT_START <= h_cnt < H_ACT_START+H_ACT_LEN` && `V_ACT_START <= v_cnt < V_ACT_START+V_ACT_LINES`.
- `pix_x` = `(h_cnt-H_ACT_START)>>1`.
- `line_y` = `v_cnt-V_ACT_START`.
- All outputs are registered.

## Timing

- `h_cnt` is 0 two clocks after the first `clk` edge that samples `h_sync` low: 2 synchronizer stages, with edge detect feeding the load.
- Outputs lag `h_cnt` by one clock.
- `de` first rises `H_ACT_START+3` clocks after the sampling edge of the `h_sync` fall.
- Each `pix_x` value is held for exactly 2 clocks while `de` is high.
- `frame_start` and `sync_err` are single-clock pulses.
- If `frame_start` and `sync_err` fall in the same cycle, both assert.
- `locked` rises in the cycle after the `frame_start` that completes the `LOCK_FRAMES`th good frame.
- `locked` falls in the cycle after a violation is detected.
- `de` is low in that same cycle.
- Asserting `reset` at any time forces every output to 0 immediately.
- After release, reacquisition restarts from ACQUIRE.

## Test plan

- Reset with syncs idle high -> all outputs 0; `locked` stays 0 for 10,000 clocks.
- Ideal generator stream (833,600 clocks per frame) -> `locked`=1 after 2 full frames. Each locked frame then shows:
  - exactly 614,400 `de` clocks;
  - `pix_x` sweeps 0..639 per line;
  - `line_y` sweeps 0..479;
  - one `frame_start`;
  - no `sync_err`.
- One line stretched to 1601 clocks while locked -> `sync_err` pulses at that line's end and `locked` drops to 0. `locked` returns after 2 subsequent good frames.
- `h_sync` held high while locked -> `sync_err` pulses when `h_cnt` hits 2047, and `locked` drops to 0. Relock follows after normal syncs resume.
- A frame of 520 lines -> `sync_err` pulses at its `frame_start` and the lock sequence restarts.
- `reset` pulsed mid-frame while locked -> all outputs 0 on the same cycle, then lock again after 2 good frames.

Source files
------------

// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and regenerated timing outputs of the VGA receive-side monitor.
// The master side is the sync source (generator or capture front end); the
// slave side is the monitor itself.
interface vga_sync_monitor_if;
  logic       h_sync;
  logic       v_sync;
  logic       locked;
  logic       de;
  logic [9:0] pix_x;
  logic [8:0] line_y;
  logic       frame_start;
  logic       sync_err;

  modport master (
    output h_sync, v_sync,
    input  locked, de, pix_x, line_y, frame_start, sync_err
  );

  modport slave (
    input  h_sync, v_sync,
    output locked, de, pix_x, line_y, frame_start, sync_err
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor. Synchronizes incoming active-low syncs,
// measures sync width, line period and frame length, declares lock after a run
// of good frames and, while locked, regenerates de / pixel / line coordinates.
module vga_sync_monitor #(
  parameter int unsigned CLK_PER_LINE    = 1600,
  parameter int unsigned HS_LEN          = 192,
  parameter int unsigned H_ACT_START     = 288,
  parameter int unsigned H_ACT_LEN       = 1280,
  parameter int unsigned LINES_PER_FRAME = 521,
  parameter int unsigned V_ACT_START     = 31,
  parameter int unsigned V_ACT_LINES     = 480,
  parameter int unsigned LOCK_FRAMES     = 2
) (
  input  logic              clk,
  input  logic              reset,
  vga_sync_monitor_if.slave vga
);

  localparam logic [10:0] H_MAX    = 11'd2047;
  localparam logic [9:0]  V_MAX    = 10'd1023;
  localparam logic [11:0] HS_LEN_C = 12'(HS_LEN);
  localparam logic [11:0] CPL_C    = 12'(CLK_PER_LINE);
  localparam logic [10:0] LPF_C    = 11'(LINES_PER_FRAME);
  localparam logic [10:0] H_ACT_LO = 11'(H_ACT_START);
  localparam logic [10:0] H_ACT_HI = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [9:0]  V_ACT_LO = 10'(V_ACT_START);
  localparam logic [9:0]  V_ACT_HI = 10'(V_ACT_START + V_ACT_LINES);
  localparam int          GW       = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

  typedef enum logic {ACQUIRE, LOCKED} lock_state_e;

  // Sync capture: [0] metastability flop, [1] synchronized, [2] previous value.
  logic [2:0]    hs_pipe_q, vs_pipe_q;

  logic [10:0]   h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic          vs_pend_q, vs_pend_d;
  logic          per_valid_q, per_valid_d;   // a previous fall exists to time the period from
  logic          judged_q, judged_d;         // current frame started at a clean boundary
  lock_state_e   state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;

  logic          de_q, de_d;
  logic [9:0]    pix_x_q, pix_x_d;
  logic [8:0]    line_y_q, line_y_d;
  logic          frame_start_q;
  logic          sync_err_q;

  logic          h_fall, h_rise, v_fall, frame_bnd;
  logic [11:0]   h_len;
  logic [10:0]   v_len;
  logic          width_err, period_err, timeout, frame_err, violation, frame_good;

  assign h_fall    = hs_pipe_q[2] & ~hs_pipe_q[1];
  assign h_rise    = ~hs_pipe_q[2] & hs_pipe_q[1];
  assign v_fall    = vs_pipe_q[2] & ~vs_pipe_q[1];
  assign frame_bnd = h_fall & (vs_pend_q | v_fall);

  assign h_len      = {1'b0, h_cnt_q} + 12'd1;
  assign v_len      = {1'b0, v_cnt_q} + 11'd1;
  assign width_err  = h_rise && (h_len != HS_LEN_C);
  assign period_err = h_fall && per_valid_q && (h_len != CPL_C);
  assign timeout    = !h_fall && (h_cnt_q == H_MAX - 11'd1);
  assign frame_err  = frame_bnd && judged_q && (v_len != LPF_C);
  assign violation  = width_err | period_err | timeout | frame_err;
  assign frame_good = frame_bnd && judged_q && !violation;

  // Synchronize both syncs and keep one bit of history for edge detection.
  // NOTE: the synchronizer resets to 1 (idle) so releasing reset with the syncs high produces no false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_pipe_q <= 3'b111;
      vs_pipe_q <= 3'b111;
    end else begin
      // NOTE: non-blocking assignment so every flop captures the pre-edge value, independent of statement order.
      hs_pipe_q <= {hs_pipe_q[1:0], vga.h_sync};
      vs_pipe_q <= {vs_pipe_q[1:0], vga.v_sync};
    end
  end

  // Next-state for the line/frame counters and the measurement qualifiers.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    vs_pend_d   = vs_pend_q;
    per_valid_d = per_valid_q;
    judged_d    = judged_q;

    if (h_fall)                 h_cnt_d = '0;
    else if (h_cnt_q != H_MAX)  h_cnt_d = h_cnt_q + 11'd1;

    if (frame_bnd)                      v_cnt_d = '0;
    else if (h_fall && v_cnt_q != V_MAX) v_cnt_d = v_cnt_q + 10'd1;

    if (frame_bnd)   vs_pend_d = 1'b0;
    else if (v_fall) vs_pend_d = 1'b1;

    // After a timeout the counter no longer holds a real period.
    if (timeout)     per_valid_d = 1'b0;
    else if (h_fall) per_valid_d = 1'b1;

    // A frame is judged only if it began at a boundary with no violation since.
    if (violation)      judged_d = 1'b0;
    else if (frame_bnd) judged_d = 1'b1;
  end

  // Lock FSM: count good frames in ACQUIRE, any violation restarts acquisition.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ACQUIRE: begin
        if (good_cnt_q == LOCK_N) state_d    = LOCKED;
        else if (frame_good)      good_cnt_d = good_cnt_q + GW'(1);
      end
      LOCKED:  ;
      default: state_d = ACQUIRE;
    endcase
    if (violation) begin
      state_d    = ACQUIRE;
      good_cnt_d = '0;
    end
  end

  // Output decode; de uses the next lock state so it drops with the violation.
  always_comb begin
    de_d     = (state_d == LOCKED) &&
               (h_cnt_q >= H_ACT_LO) && (h_cnt_q < H_ACT_HI) &&
               (v_cnt_q >= V_ACT_LO) && (v_cnt_q < V_ACT_HI);
    pix_x_d  = '0;
    line_y_d = '0;
    if (de_d) begin
      pix_x_d  = 10'((h_cnt_q - H_ACT_LO) >> 1);
      line_y_d = 9'(v_cnt_q - V_ACT_LO);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vs_pend_q     <= 1'b0;
      per_valid_q   <= 1'b0;
      judged_q      <= 1'b0;
      state_q       <= ACQUIRE;
      good_cnt_q    <= '0;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      line_y_q      <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_pend_q     <= vs_pend_d;
      per_valid_q   <= per_valid_d;
      judged_q      <= judged_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      line_y_q      <= line_y_d;
      frame_start_q <= frame_bnd;
      sync_err_q    <= violation;
    end
  end

  assign vga.locked      = (state_q == LOCKED);
  assign vga.de          = de_q;
  assign vga.pix_x       = pix_x_q;
  assign vga.line_y      = line_y_q;
  assign vga.frame_start = frame_start_q;
  assign vga.sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a scaled-down raster: 40-clock lines
// (6 low), active clocks 10..29 (10 pixels), 12-line frames, active lines 3..8.
module tb_vga_sync_monitor;

  localparam int CPL   = 40;
  localparam int HS    = 6;
  localparam int HAS   = 10;
  localparam int HAL   = 20;
  localparam int LPF   = 12;
  localparam int VAS   = 3;
  localparam int VAL   = 6;
  localparam int LOCKN = 2;

  // Hand-computed expectations for this raster.
  localparam int DE_PER_FRAME = 120;   // 20 clocks x 6 lines
  localparam int DE_LAT       = 13;    // H_ACT_START + 3
  localparam int FS_LAT       = 2;     // sampling edge -> frame_start
  localparam int LOCK_LAT     = 3;     // one cycle after frame_start
  localparam int ERR_LAT      = 2;     // period / frame error at the fall
  localparam int TO_LAT       = 2049;  // h_cnt 0 at +2, reaches 2047 at +2049

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_sync_monitor_if vga ();

  vga_sync_monitor #(
    .CLK_PER_LINE(CPL), .HS_LEN(HS), .H_ACT_START(HAS), .H_ACT_LEN(HAL),
    .LINES_PER_FRAME(LPF), .V_ACT_START(VAS), .V_ACT_LINES(VAL), .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vga  (vga)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle index of the most recent rising edge.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int hfall_edge = 0;   // edge that first samples the latest h_sync fall

  // Monitor counters, sampled on the falling edge.
  int fs_cnt = 0, err_cnt = 0, de_cnt = 0, lock_hi_cnt = 0, fs_err_both = 0;
  int seq_bad = 0, lat_bad = 0;
  int fs_delta = 0, err_delta = 0, lock_fs = 0, lock_delta = 0, lock_fall_delta = 0;
  int de_at_err = 0;
  int run_k = 0, run_idx = 0;
  logic lock_prev = 1'b0, de_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (vga.frame_start) begin
      fs_cnt++;
      fs_delta = cyc - hfall_edge;
      run_idx  = 0;
      if (vga.sync_err) fs_err_both++;
    end
    if (vga.sync_err) begin
      err_cnt++;
      err_delta = cyc - hfall_edge;
      de_at_err = int'(vga.de);
    end
    if (vga.locked && !lock_prev) begin
      lock_fs    = fs_cnt;
      lock_delta = cyc - hfall_edge;
    end
    if (!vga.locked && lock_prev) lock_fall_delta = cyc - hfall_edge;
    if (vga.locked) lock_hi_cnt++;
    if (vga.de) begin
      de_cnt++;
      if (!de_prev) begin
        run_k = 0;
        if (cyc - hfall_edge != DE_LAT) lat_bad++;
      end
      if (int'(vga.pix_x) != run_k / 2 || int'(vga.line_y) != run_idx) seq_bad++;
      run_k++;
    end else begin
      if (de_prev) begin
        if (run_k != HAL) seq_bad++;
        run_idx++;
      end
      if (vga.pix_x != 10'd0 || vga.line_y != 9'd0) seq_bad++;
    end
    lock_prev = vga.locked;
    de_prev   = vga.de;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int len, input bit vs_low);
    vga.h_sync = 1'b0;
    vga.v_sync = vs_low ? 1'b0 : 1'b1;
    hfall_edge = cyc + 1;
    repeat (HS) tick();
    vga.h_sync = 1'b1;
    repeat (len - HS) tick();
  endtask

  task automatic drive_frame(input int nlines, input int stretch);
    for (int l = 0; l < nlines; l++)
      drive_line((l == stretch) ? CPL + 1 : CPL, l < 2);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_locked"}, int'(vga.locked), 0);
    check({pfx, "_de"}, int'(vga.de), 0);
    check({pfx, "_pix_x"}, int'(vga.pix_x), 0);
    check({pfx, "_line_y"}, int'(vga.line_y), 0);
    check({pfx, "_frame_start"}, int'(vga.frame_start), 0);
    check({pfx, "_sync_err"}, int'(vga.sync_err), 0);
  endtask

  int b_a, b_b, b_c, b_d, b_e;

  initial begin
    reset      = 1'b1;
    vga.h_sync = 1'b1;
    vga.v_sync = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    tick();
    reset = 1'b0;

    // Idle syncs: never locks.
    b_a = lock_hi_cnt; b_b = de_cnt;
    repeat (10000) tick();
    check("idle_locked_cycles", lock_hi_cnt - b_a, 0);
    check("idle_de_cycles", de_cnt - b_b, 0);

    // Acquisition: lock one cycle after the third frame_start.
    b_a = fs_cnt;
    repeat (3) drive_frame(LPF, -1);
    check("acq_lock_fs", lock_fs - b_a, 3);
    check("acq_lock_lat", lock_delta, LOCK_LAT);
    check("acq_locked", int'(vga.locked), 1);

    // Locked frames: full de sweep, one frame_start, no errors.
    for (int f = 0; f < 2; f++) begin
      b_a = de_cnt; b_b = fs_cnt; b_c = err_cnt; b_d = seq_bad; b_e = lat_bad;
      drive_frame(LPF, -1);
      check("frm_de_cycles", de_cnt - b_a, DE_PER_FRAME);
      check("frm_frame_starts", fs_cnt - b_b, 1);
      check("frm_sync_errs", err_cnt - b_c, 0);
      check("frm_pix_line_seq", seq_bad - b_d, 0);
      check("frm_de_latency", lat_bad - b_e, 0);
      check("frm_fs_lat", fs_delta, FS_LAT);
    end

    // Stretched line: error and unlock two clocks after the next fall.
    b_a = err_cnt;
    drive_frame(LPF, 5);
    check("str_err_cnt", err_cnt - b_a, 1);
    check("str_err_lat", err_delta, ERR_LAT);
    check("str_unlock_lat", lock_fall_delta, ERR_LAT);
    check("str_de_at_err", de_at_err, 0);
    check("str_locked", int'(vga.locked), 0);
    b_a = fs_cnt; b_b = err_cnt;
    repeat (3) drive_frame(LPF, -1);
    check("str_relock_fs", lock_fs - b_a, 3);
    check("str_relock_errs", err_cnt - b_b, 0);
    check("str_relocked", int'(vga.locked), 1);

    // h_sync held high: timeout when h_cnt saturates.
    b_a = err_cnt;
    repeat (2100) tick();
    check("to_err_cnt", err_cnt - b_a, 1);
    check("to_err_lat", err_delta, TO_LAT);
    check("to_locked", int'(vga.locked), 0);
    b_a = fs_cnt;
    repeat (3) drive_frame(LPF, -1);
    check("to_relock_fs", lock_fs - b_a, 3);
    check("to_relocked", int'(vga.locked), 1);

    // Short frame: error coincides with the next frame_start; the frame after
    // it is unjudged, so lock returns at the fourth frame_start.
    drive_frame(LPF - 1, -1);
    b_a = err_cnt; b_b = fs_err_both; b_c = fs_cnt;
    repeat (4) drive_frame(LPF, -1);
    check("short_err_cnt", err_cnt - b_a, 1);
    check("short_err_with_fs", fs_err_both - b_b, 1);
    check("short_relock_fs", lock_fs - b_c, 4);
    check("short_relocked", int'(vga.locked), 1);

    // Reset mid-frame while de is active on line 4.
    for (int l = 0; l < 4; l++) drive_line(CPL, l < 2);
    vga.h_sync = 1'b0;
    vga.v_sync = 1'b1;
    hfall_edge = cyc + 1;
    repeat (HS) tick();
    vga.h_sync = 1'b1;
    repeat (12) tick();
    check("mid_de", int'(vga.de), 1);
    check("mid_pix_x", int'(vga.pix_x), 2);
    check("mid_line_y", int'(vga.line_y), 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    for (int l = 5; l < LPF; l++) drive_line(CPL, 1'b0);
    b_a = fs_cnt;
    repeat (3) drive_frame(LPF, -1);
    check("rst_relock_fs", lock_fs - b_a, 3);
    check("rst_relocked", int'(vga.locked), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
